// File: rtl/uart_rx_frame.sv
// 8N1 serial receiver: synchronised input, start-bit validation, 3-sample
// majority vote at each bit centre, framing-error strobe, no data on bad frames.
module uart_rx_frame #(
  parameter int unsigned BPS_PARAM = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ttl_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned HALF     = BPS_PARAM / 2;
  localparam logic [15:0] BPS_LAST = 16'(BPS_PARAM - 1);
  localparam logic [15:0] SAMP0    = 16'(HALF - 1);
  localparam logic [15:0] SAMP1    = 16'(HALF);
  localparam logic [15:0] SAMP2    = 16'(HALF + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t      state;
  logic        rx_m;
  logic        rx_s;
  logic        rx_d;
  logic [1:0]  fill;
  logic        armed;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        samp0;
  logic        samp1;
  logic        fall;
  logic        decide;
  logic        bit_val;

  // Edges are only honoured once rx_s has carried a real high level since
  // reset, so a line already held low at reset release never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      rx_m <= ttl_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (fill == 2'd2 && rx_s) armed <= 1'b1;
    end
  end

  assign fall    = armed && rx_d && !rx_s;
  assign decide  = (cnt == SAMP2);
  assign bit_val = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      samp0        <= 1'b1;
      samp1        <= 1'b1;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;

      // Timer is held at zero while idle so START is always entered with cnt=0.
      if (state == IDLE || state == WAIT_HIGH) cnt <= '0;
      else if (cnt == BPS_LAST)                cnt <= '0;
      else                                     cnt <= cnt + 16'd1;

      if (cnt == SAMP0) samp0 <= rx_s;
      if (cnt == SAMP1) samp1 <= rx_s;

      case (state)
        IDLE: begin
          if (fall) state <= START;
        end
        START: begin
          if (decide) begin
            if (bit_val) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end
        end
        DATA: begin
          if (decide) begin
            shreg[idx] <= bit_val;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end
        end
        STOP: begin
          if (decide) begin
            if (bit_val) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: expected strobes and data come from a
// frame-level event model checked every cycle, plus literal spot checks.
module tb_uart_rx_frame;

  localparam int BPS  = 100;
  localparam int HALF = BPS / 2;
  // line fall -> strobe: 3 (sync+edge) + 9 bits + HALF + decision + register
  localparam int LAT  = 3 + 9 * BPS + HALF + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ttl_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx_frame #(.BPS_PARAM(BPS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ttl_rx       (ttl_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         at;
    bit         err;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] model_data = 8'h00;
  int         nvalid = 0;
  int         nerr = 0;
  int         last_valid_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the event model.
  always @(negedge clk) begin
    logic ev_v;
    logic ev_e;
    ev_v = 1'b0;
    ev_e = 1'b0;
    if (!rst_n) begin
      model_data = 8'h00;
    end else if (evq.size() > 0 && evq[0].at == cyc) begin
      if (evq[0].err) begin
        ev_e = 1'b1;
      end else begin
        ev_v = 1'b1;
        model_data = evq[0].data;
      end
      void'(evq.pop_front());
    end
    check("rx_valid", rx_valid, ev_v);
    check("rx_frame_err", rx_frame_err, ev_e);
    check("rx_data", rx_data, model_data);
    if (rx_valid) begin
      nvalid++;
      last_valid_cyc = cyc;
    end
    if (rx_frame_err) nerr++;
  end

  function automatic logic line_bit(input logic [7:0] d, input int o, input logic stop_val);
    int b;
    b = o / BPS;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return stop_val;
  endfunction

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      ttl_rx = v;
      @(posedge clk);
      #1;
    end
  endtask

  // One frame; stop_len cycles of stop level (high if good, low if not);
  // glitch_off inverts the line for one cycle at that offset (-1 = none).
  task automatic send(input logic [7:0] d, input int stop_len, input int glitch_off,
                      input bit good, output int p);
    ev_t e;
    p = cyc;
    e.at   = p + LAT;
    e.err  = !good;
    e.data = d;
    evq.push_back(e);
    for (int o = 0; o < 9 * BPS + stop_len; o++) begin
      logic v;
      v = line_bit(d, o, good ? 1'b1 : 1'b0);
      if (o == glitch_off) v = ~v;
      ttl_rx = v;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int p;
    rst_n  = 1'b0;
    ttl_rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_rx_frame_err", rx_frame_err, 1'b0);
    check("reset_rx_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 20);

    // False start: 30-cycle low glitch, rejected at the start decision.
    p = cyc;
    drive(1'b0, 30);
    drive(1'b1, 23);
    check("false_start_busy_high", rx_busy, 1'b1);
    drive(1'b1, 3);
    check("false_start_busy_low", rx_busy, 1'b0);
    drive(1'b1, 50);
    check("false_start_data", rx_data, 8'h00);
    check("false_start_nvalid", nvalid, 0);
    check("false_start_nerr", nerr, 0);

    // Clean 0xA5.
    send(8'hA5, BPS, -1, 1'b1, p);
    drive(1'b1, 20);
    check("a5_data", rx_data, 8'hA5);
    check("a5_nvalid", nvalid, 1);
    check("a5_latency", last_valid_cyc - p, 955);
    check("a5_nerr", nerr, 0);

    // 0x3C with stop held low for three bit times.
    send(8'h3C, 3 * BPS, -1, 1'b0, p);
    check("ferr_busy_while_low", rx_busy, 1'b1);
    drive(1'b1, 10);
    check("ferr_busy_after_high", rx_busy, 1'b0);
    drive(1'b1, 1100);
    check("ferr_nerr", nerr, 1);
    check("ferr_nvalid", nvalid, 1);
    check("ferr_data_kept", rx_data, 8'hA5);

    // Back-to-back 0x00 then 0xFF.
    send(8'h00, BPS, -1, 1'b1, p);
    send(8'hFF, BPS, -1, 1'b1, p);
    drive(1'b1, 20);
    check("b2b_data", rx_data, 8'hFF);
    check("b2b_nvalid", nvalid, 3);
    check("b2b_nerr", nerr, 1);

    // 0x81 with a one-cycle high spike seen by the cnt==HALF sample of bit 3.
    send(8'h81, BPS, 4 * BPS + HALF + 1, 1'b1, p);
    drive(1'b1, 20);
    check("spike_data", rx_data, 8'h81);
    check("spike_nvalid", nvalid, 4);

    // Reset during bit 4 of 0xE7 (line low there), released with line still low.
    for (int o = 0; o < 5 * BPS + HALF; o++) drive(line_bit(8'hE7, o, 1'b1), 1);
    rst_n = 1'b0;
    drive(1'b0, 1);
    check("abort_rx_data", rx_data, 8'h00);
    check("abort_rx_valid", rx_valid, 1'b0);
    check("abort_rx_frame_err", rx_frame_err, 1'b0);
    check("abort_rx_busy", rx_busy, 1'b0);
    drive(1'b0, 20);
    rst_n = 1'b1;
    drive(1'b0, 60);
    check("low_line_not_start", rx_busy, 1'b0);
    drive(1'b1, 200);
    send(8'h5A, BPS, -1, 1'b1, p);
    drive(1'b1, 20);
    check("after_abort_data", rx_data, 8'h5A);
    check("after_abort_nvalid", nvalid, 5);
    check("after_abort_nerr", nerr, 1);
    check("events_pending", evq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
